// File: rtl/fib_pkg.sv
// Shared FIB hash-path definitions: widths, requester ids and the in-flight tag.
package fib_pkg;

    localparam int unsigned PREFIX_W = 64;
    localparam int unsigned LEN_W    = 6;
    localparam int unsigned HASH_W   = 10;

    localparam logic REQ_SAVE   = 1'b0;
    localparam logic REQ_LOOKUP = 1'b1;

    typedef struct packed {
        logic valid;
        logic id;
    } tag_t;

endpackage

// File: rtl/fib_tag_pipe.sv
// Shift register of request tags that tracks which requester owns each hash in flight.
module fib_tag_pipe
    import fib_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  tag_t tag_in,
    output tag_t tag_out,
    output logic busy
);

    tag_t [DEPTH-1:0] stage_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage_q <= '0;
        end else begin
            stage_q[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            busy = busy | stage_q[i].valid;
        end
    end

    assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/fib_hash_arbiter.sv
// Round-robin share of the FIB hash unit between the save and lookup paths, routing each
// hash result back to the requester that issued it.
module fib_hash_arbiter #(
    parameter int unsigned HASH_LAT = 1,
    parameter int unsigned MAX_OUT  = 1,
    parameter int unsigned PREFIX_W = fib_pkg::PREFIX_W,
    parameter int unsigned LEN_W    = fib_pkg::LEN_W,
    parameter int unsigned HASH_W   = fib_pkg::HASH_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                s_req,
    input  logic [PREFIX_W-1:0] s_prefix,
    input  logic [LEN_W-1:0]    s_len,
    output logic                s_gnt,
    output logic                s_rsp_valid,
    output logic [HASH_W-1:0]   s_rsp_hash,
    input  logic                l_req,
    input  logic [PREFIX_W-1:0] l_prefix,
    input  logic [LEN_W-1:0]    l_len,
    output logic                l_gnt,
    output logic                l_rsp_valid,
    output logic [HASH_W-1:0]   l_rsp_hash,
    output logic [PREFIX_W-1:0] h_prefix,
    output logic [LEN_W-1:0]    h_len,
    input  logic [HASH_W-1:0]   h_value,
    output logic                busy
);

    import fib_pkg::*;

    localparam int unsigned DEPTH   = 1 + HASH_LAT;
    localparam logic [1:0]  MAX_CNT = 2'(MAX_OUT);

    logic [1:0]          s_cnt_q, s_cnt_d, l_cnt_q, l_cnt_d;
    logic                rr_q;
    logic [PREFIX_W-1:0] h_prefix_q;
    logic [LEN_W-1:0]    h_len_q;
    tag_t                tag_in, tag_out;
    logic                s_dec, l_dec, s_elig, l_elig, s_win, l_win;

    assign s_dec = tag_out.valid && (tag_out.id == REQ_SAVE);
    assign l_dec = tag_out.valid && (tag_out.id == REQ_LOOKUP);

    // A response leaving this cycle frees its slot for a same-cycle grant.
    assign s_elig = rst && s_req && ((s_cnt_q < MAX_CNT) || s_dec);
    assign l_elig = rst && l_req && ((l_cnt_q < MAX_CNT) || l_dec);

    always_comb begin
        s_win = 1'b0;
        l_win = 1'b0;
        if (s_elig && l_elig) begin
            s_win = (rr_q == REQ_SAVE);
            l_win = (rr_q == REQ_LOOKUP);
        end else begin
            s_win = s_elig;
            l_win = l_elig;
        end
    end

    always_comb begin
        tag_in       = '0;
        tag_in.valid = s_win || l_win;
        tag_in.id    = l_win ? REQ_LOOKUP : REQ_SAVE;
    end

    assign s_cnt_d = s_cnt_q + {1'b0, s_win} - {1'b0, s_dec};
    assign l_cnt_d = l_cnt_q + {1'b0, l_win} - {1'b0, l_dec};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_q       <= REQ_SAVE;
            s_cnt_q    <= '0;
            l_cnt_q    <= '0;
            h_prefix_q <= '0;
            h_len_q    <= '0;
        end else begin
            s_cnt_q <= s_cnt_d;
            l_cnt_q <= l_cnt_d;
            if (s_win) begin
                rr_q       <= REQ_LOOKUP;
                h_prefix_q <= s_prefix;
                h_len_q    <= s_len;
            end else if (l_win) begin
                rr_q       <= REQ_SAVE;
                h_prefix_q <= l_prefix;
                h_len_q    <= l_len;
            end
        end
    end

    fib_tag_pipe #(
        .DEPTH (DEPTH)
    ) u_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .tag_in  (tag_in),
        .tag_out (tag_out),
        .busy    (busy)
    );

    assign s_gnt       = s_win;
    assign l_gnt       = l_win;
    assign h_prefix    = h_prefix_q;
    assign h_len       = h_len_q;
    assign s_rsp_valid = s_dec;
    assign l_rsp_valid = l_dec;
    assign s_rsp_hash  = s_dec ? h_value : '0;
    assign l_rsp_hash  = l_dec ? h_value : '0;

endmodule
